// File: rtl/l1_mem_pkg.sv
// Shared types, constants and helpers for the L1 refill controller.
//   state_e     : refill FSM states
//   l1_req_t    : latched L1 request payload
//   line_base() : byte address -> cache line base address
package l1_mem_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ACK_W      = 4;
  localparam int unsigned LINE_BYTES = 32;
  localparam logic [ACK_W-1:0] IDX_NONE = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_LDATA = 3'd3,
    ST_SDATA = 3'd4,
    ST_FIN   = 3'd5
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } l1_req_t;

  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Progress watchdog: counts enabled cycles since the last clear.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart the count (has priority over en)
//   en         : count this cycle
//   expired_c  : count has reached LIMIT-1, i.e. this is the LIMIT-th idle cycle
module mem_timeout_ctr #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q;

  assign expired_c = (cnt_q == CW'(LIMIT - 1));

  // Saturates at the expiry value so it never wraps back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired_c) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/l1_refill_controller.sv
// L1 miss / write-through to main-memory sequencer.
//   L1 side  : REQ_VALID/REQ_WRITE/REQ_ADDR/REQ_WDATA in, REQ_READY out;
//              FILL_VALID/FILL_IDX/FILL_DATA/FILL_LINE_ADDR fill beats; DONE / ERR pulses.
//   Mem side : MEM_VALID/MEM_LOAD/MEM_STORE + MEM_READY handshake, MEM_ADDR/MEM_ADDR_VALID
//              + MEM_ADDR_TAKEN, MEM_RDATA/MEM_WDATA, MEM_ACK_DATA_MEM/MEM_ACK_DATA_L1 word index.
// All outputs are registered; each *_d is the value the output takes after the next edge.
module l1_refill_controller
  import l1_mem_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              REQ_VALID,
  input  logic                              REQ_WRITE,
  input  logic [ADDR_W-1:0]                 REQ_ADDR,
  input  logic [DATA_W-1:0]                 REQ_WDATA,
  output logic                              REQ_READY,
  output logic                              FILL_VALID,
  output logic [$clog2(WORDS_PER_LINE)-1:0] FILL_IDX,
  output logic [DATA_W-1:0]                 FILL_DATA,
  output logic [ADDR_W-1:0]                 FILL_LINE_ADDR,
  output logic                              DONE,
  output logic                              ERR,
  output logic                              MEM_VALID,
  output logic                              MEM_LOAD,
  output logic                              MEM_STORE,
  input  logic                              MEM_READY,
  output logic [ADDR_W-1:0]                 MEM_ADDR,
  output logic                              MEM_ADDR_VALID,
  input  logic                              MEM_ADDR_TAKEN,
  input  logic [DATA_W-1:0]                 MEM_RDATA,
  output logic [DATA_W-1:0]                 MEM_WDATA,
  input  logic [ACK_W-1:0]                  MEM_ACK_DATA_MEM,
  output logic [ACK_W-1:0]                  MEM_ACK_DATA_L1
);

  localparam int unsigned IDX_W = $clog2(WORDS_PER_LINE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  state_e            state_q, state_d;
  l1_req_t           req_q, req_d;
  logic [IDX_W-1:0]  exp_idx_q, exp_idx_d;

  logic              req_ready_d, fill_valid_d, done_d, err_d;
  logic [IDX_W-1:0]  fill_idx_d;
  logic [DATA_W-1:0] fill_data_d, mem_wdata_d;
  logic [ADDR_W-1:0] fill_line_addr_d, mem_addr_d;
  logic              mem_valid_d, mem_load_d, mem_store_d, mem_addr_valid_d;
  logic [ACK_W-1:0]  mem_ack_l1_d;

  logic              word_taken;
  logic              tmo_clr, tmo_en, tmo_expired_c;

  // No-progress watchdog: restarts on any state change or accepted fill word.
  assign tmo_clr = (state_d != state_q) || word_taken;
  assign tmo_en  = (state_q != ST_IDLE);

  mem_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .clr       (tmo_clr),
    .en        (tmo_en),
    .expired_c (tmo_expired_c)
  );

  // State and registered-output update.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q         <= ST_IDLE;
      req_q           <= '0;
      exp_idx_q       <= '0;
      REQ_READY       <= 1'b1;
      FILL_VALID      <= 1'b0;
      FILL_IDX        <= '0;
      FILL_DATA       <= '0;
      FILL_LINE_ADDR  <= '0;
      DONE            <= 1'b0;
      ERR             <= 1'b0;
      MEM_VALID       <= 1'b0;
      MEM_LOAD        <= 1'b0;
      MEM_STORE       <= 1'b0;
      MEM_ADDR        <= '0;
      MEM_ADDR_VALID  <= 1'b0;
      MEM_WDATA       <= '0;
      MEM_ACK_DATA_L1 <= IDX_NONE;
    end else begin
      state_q         <= state_d;
      req_q           <= req_d;
      exp_idx_q       <= exp_idx_d;
      REQ_READY       <= req_ready_d;
      FILL_VALID      <= fill_valid_d;
      FILL_IDX        <= fill_idx_d;
      FILL_DATA       <= fill_data_d;
      FILL_LINE_ADDR  <= fill_line_addr_d;
      DONE            <= done_d;
      ERR             <= err_d;
      MEM_VALID       <= mem_valid_d;
      MEM_LOAD        <= mem_load_d;
      MEM_STORE       <= mem_store_d;
      MEM_ADDR        <= mem_addr_d;
      MEM_ADDR_VALID  <= mem_addr_valid_d;
      MEM_WDATA       <= mem_wdata_d;
      MEM_ACK_DATA_L1 <= mem_ack_l1_d;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    exp_idx_d        = exp_idx_q;
    req_ready_d      = 1'b0;
    fill_valid_d     = 1'b0;
    fill_idx_d       = FILL_IDX;
    fill_data_d      = FILL_DATA;
    fill_line_addr_d = FILL_LINE_ADDR;
    done_d           = 1'b0;
    err_d            = 1'b0;
    mem_valid_d      = MEM_VALID;
    mem_load_d       = MEM_LOAD;
    mem_store_d      = MEM_STORE;
    mem_addr_d       = MEM_ADDR;
    mem_addr_valid_d = MEM_ADDR_VALID;
    mem_wdata_d      = MEM_WDATA;
    mem_ack_l1_d     = MEM_ACK_DATA_L1;
    word_taken       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (REQ_VALID) begin
          req_d.write      = REQ_WRITE;
          req_d.addr       = {REQ_ADDR[ADDR_W-1:2], 2'b00};
          req_d.wdata      = REQ_WDATA;
          fill_line_addr_d = line_base(REQ_ADDR);
          mem_valid_d      = 1'b1;
          mem_load_d       = !REQ_WRITE;
          mem_store_d      = REQ_WRITE;
          state_d          = ST_REQ;
        end
      end

      ST_REQ: begin
        if (MEM_READY) begin
          mem_addr_valid_d = 1'b1;
          mem_addr_d       = req_q.write ? req_q.addr : line_base(req_q.addr);
          state_d          = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (MEM_ADDR_TAKEN) begin
          mem_addr_valid_d = 1'b0;
          if (req_q.write) begin
            mem_wdata_d  = req_q.wdata;
            mem_ack_l1_d = '0;
            state_d      = ST_SDATA;
          end else begin
            exp_idx_d = '0;
            state_d   = ST_LDATA;
          end
        end
      end

      // Only the expected index is consumed; repeats and out-of-order indices are dropped.
      ST_LDATA: begin
        if (MEM_ACK_DATA_MEM == ACK_W'(exp_idx_q)) begin
          word_taken   = 1'b1;
          fill_valid_d = 1'b1;
          fill_idx_d   = exp_idx_q;
          fill_data_d  = MEM_RDATA;
          mem_ack_l1_d = ACK_W'(exp_idx_q);
          if (exp_idx_q == LAST_IDX) begin
            state_d = ST_FIN;
          end else begin
            exp_idx_d = exp_idx_q + IDX_W'(1);
          end
        end
      end

      ST_SDATA: begin
        if (!MEM_READY) begin
          state_d = ST_FIN;
        end
      end

      // MEM_VALID is still high only on the first FIN cycle, which bounds DONE to one pulse.
      ST_FIN: begin
        done_d       = MEM_VALID;
        mem_valid_d  = 1'b0;
        mem_load_d   = 1'b0;
        mem_store_d  = 1'b0;
        mem_ack_l1_d = IDX_NONE;
        if (!MEM_READY) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abandon a stalled transaction: memory side back to reset values, no DONE.
    if ((state_q != ST_IDLE) && tmo_expired_c) begin
      state_d          = ST_IDLE;
      err_d            = 1'b1;
      done_d           = 1'b0;
      fill_valid_d     = 1'b0;
      exp_idx_d        = '0;
      mem_valid_d      = 1'b0;
      mem_load_d       = 1'b0;
      mem_store_d      = 1'b0;
      mem_addr_d       = '0;
      mem_addr_valid_d = 1'b0;
      mem_wdata_d      = '0;
      mem_ack_l1_d     = IDX_NONE;
    end

    req_ready_d = (state_d == ST_IDLE);
  end

endmodule

// File: tb/tb_l1_refill_controller.sv
// Directed self-checking bench for l1_refill_controller.
module tb_l1_refill_controller;

  logic        CLK, RST_N;
  logic        REQ_VALID, REQ_WRITE;
  logic [31:0] REQ_ADDR, REQ_WDATA;
  logic        REQ_READY, FILL_VALID;
  logic [2:0]  FILL_IDX;
  logic [31:0] FILL_DATA, FILL_LINE_ADDR;
  logic        DONE, ERR, MEM_VALID, MEM_LOAD, MEM_STORE, MEM_READY;
  logic [31:0] MEM_ADDR;
  logic        MEM_ADDR_VALID, MEM_ADDR_TAKEN;
  logic [31:0] MEM_RDATA, MEM_WDATA;
  logic [3:0]  MEM_ACK_DATA_MEM, MEM_ACK_DATA_L1;

  int n_checks = 0;
  int n_fail   = 0;
  int fill_cnt = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int txn_cnt  = 0;
  logic mv_prev = 1'b0;

  l1_refill_controller dut (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .REQ_VALID        (REQ_VALID),
    .REQ_WRITE        (REQ_WRITE),
    .REQ_ADDR         (REQ_ADDR),
    .REQ_WDATA        (REQ_WDATA),
    .REQ_READY        (REQ_READY),
    .FILL_VALID       (FILL_VALID),
    .FILL_IDX         (FILL_IDX),
    .FILL_DATA        (FILL_DATA),
    .FILL_LINE_ADDR   (FILL_LINE_ADDR),
    .DONE             (DONE),
    .ERR              (ERR),
    .MEM_VALID        (MEM_VALID),
    .MEM_LOAD         (MEM_LOAD),
    .MEM_STORE        (MEM_STORE),
    .MEM_READY        (MEM_READY),
    .MEM_ADDR         (MEM_ADDR),
    .MEM_ADDR_VALID   (MEM_ADDR_VALID),
    .MEM_ADDR_TAKEN   (MEM_ADDR_TAKEN),
    .MEM_RDATA        (MEM_RDATA),
    .MEM_WDATA        (MEM_WDATA),
    .MEM_ACK_DATA_MEM (MEM_ACK_DATA_MEM),
    .MEM_ACK_DATA_L1  (MEM_ACK_DATA_L1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Event monitor: fill beats, DONE/ERR pulses, memory transactions started.
  always @(negedge CLK) begin
    if (FILL_VALID) fill_cnt++;
    if (DONE) done_cnt++;
    if (ERR) err_cnt++;
    if (MEM_VALID && !mv_prev) txn_cnt++;
    mv_prev = MEM_VALID;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] base, input int i);
    return 32'hC0DE_0000 ^ {base[15:0], 16'(i)};
  endfunction

  // Line fill with a zero-wait memory. rep3 repeats index 3 once; busy keeps
  // REQ_VALID high through the fill; stop_after >= 0 returns right after that beat.
  task automatic do_load(input logic [31:0] addr, input logic [31:0] base,
                         input bit rep3, input bit busy, input int stop_after);
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = addr;
    @(negedge CLK);
    if (busy) REQ_ADDR = addr ^ 32'h0000_1000;
    else REQ_VALID = 1'b0;
    check("ld_req_ready", 32'(REQ_READY), 32'd0);
    check("ld_mem_valid", 32'(MEM_VALID), 32'd1);
    check("ld_mem_load",  32'(MEM_LOAD),  32'd1);
    check("ld_mem_store", 32'(MEM_STORE), 32'd0);
    MEM_READY = 1'b1;
    @(negedge CLK);
    check("ld_addr_valid", 32'(MEM_ADDR_VALID), 32'd1);
    check("ld_mem_addr", MEM_ADDR, base);
    MEM_ADDR_TAKEN = 1'b1;
    @(negedge CLK);
    check("ld_addr_drop", 32'(MEM_ADDR_VALID), 32'd0);
    MEM_ADDR_TAKEN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      MEM_ACK_DATA_MEM = 4'(i);
      MEM_RDATA = word_of(base, i);
      @(negedge CLK);
      check("ld_fill_valid", 32'(FILL_VALID), 32'd1);
      check("ld_fill_idx", 32'(FILL_IDX), 32'(i));
      check("ld_fill_data", FILL_DATA, word_of(base, i));
      check("ld_ack_l1", 32'(MEM_ACK_DATA_L1), 32'(i));
      check("ld_no_early_done", 32'(DONE), 32'd0);
      if (stop_after == i) return;
      if (rep3 && i == 3) begin
        MEM_RDATA = 32'hBAD0_0003;
        @(negedge CLK);
        check("rep_no_fill", 32'(FILL_VALID), 32'd0);
        check("rep_ack_hold", 32'(MEM_ACK_DATA_L1), 32'd3);
      end
      if (busy && i == 5) REQ_VALID = 1'b0;
    end
    MEM_READY = 1'b0;
    MEM_ACK_DATA_MEM = 4'hF;
    @(negedge CLK);
    check("ld_done", 32'(DONE), 32'd1);
    check("ld_ack_none", 32'(MEM_ACK_DATA_L1), 32'hF);
    check("ld_mem_valid_off", 32'(MEM_VALID), 32'd0);
    check("ld_req_ready_back", 32'(REQ_READY), 32'd1);
    check("ld_line_addr", FILL_LINE_ADDR, base);
    @(negedge CLK);
    check("ld_done_pulse", 32'(DONE), 32'd0);
  endtask

  initial begin
    int fill_snap, txn_snap, n;
    RST_N = 1'b0;
    REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
    MEM_READY = 1'b0; MEM_ADDR_TAKEN = 1'b0; MEM_RDATA = '0; MEM_ACK_DATA_MEM = 4'hF;
    repeat (3) @(negedge CLK);
    check("rst_req_ready", 32'(REQ_READY), 32'd1);
    check("rst_ack_l1", 32'(MEM_ACK_DATA_L1), 32'hF);
    check("rst_mem_valid", 32'(MEM_VALID), 32'd0);
    check("rst_fill_valid", 32'(FILL_VALID), 32'd0);
    check("rst_done_err", 32'({DONE, ERR}), 32'd0);
    RST_N = 1'b1;

    // Basic line fill.
    do_load(32'h0000_0047, 32'h0000_0040, 1'b0, 1'b0, -1);
    #1;
    check("t1_fill_cnt", 32'(fill_cnt), 32'd8);

    // Word store.
    fill_snap = fill_cnt;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WRITE = 1'b1; REQ_ADDR = 32'h0000_0106; REQ_WDATA = 32'hDEAD_BEEF;
    @(negedge CLK);
    REQ_VALID = 1'b0; REQ_WRITE = 1'b0;
    check("st_mem_store", 32'(MEM_STORE), 32'd1);
    check("st_mem_load", 32'(MEM_LOAD), 32'd0);
    MEM_READY = 1'b1;
    @(negedge CLK);
    check("st_addr_valid", 32'(MEM_ADDR_VALID), 32'd1);
    check("st_mem_addr", MEM_ADDR, 32'h0000_0104);
    MEM_ADDR_TAKEN = 1'b1;
    @(negedge CLK);
    MEM_ADDR_TAKEN = 1'b0;
    check("st_wdata", MEM_WDATA, 32'hDEAD_BEEF);
    check("st_ack_l1", 32'(MEM_ACK_DATA_L1), 32'd0);
    @(negedge CLK);
    check("st_wait_done", 32'(DONE), 32'd0);
    MEM_READY = 1'b0;
    @(negedge CLK);
    check("st_fin_done", 32'(DONE), 32'd0);
    @(negedge CLK);
    check("st_done", 32'(DONE), 32'd1);
    check("st_req_ready", 32'(REQ_READY), 32'd1);
    check("st_store_off", 32'({MEM_VALID, MEM_STORE}), 32'd0);
    check("st_ack_none", 32'(MEM_ACK_DATA_L1), 32'hF);
    #1;
    check("st_no_fill", 32'(fill_cnt - fill_snap), 32'd0);

    // Repeated index 3.
    fill_snap = fill_cnt;
    do_load(32'h1234_5678, 32'h1234_5660, 1'b1, 1'b0, -1);
    #1;
    check("rep_fill_cnt", 32'(fill_cnt - fill_snap), 32'd8);

    // Address phase never acknowledged.
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 32'h0000_0500;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    MEM_READY = 1'b1;
    @(negedge CLK);
    check("tmo_addr_valid", 32'(MEM_ADDR_VALID), 32'd1);
    n = 0;
    while (!ERR && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check("tmo_cycles", 32'(n), 32'd256);
    check("tmo_err", 32'(ERR), 32'd1);
    check("tmo_no_done", 32'(DONE), 32'd0);
    check("tmo_req_ready", 32'(REQ_READY), 32'd1);
    check("tmo_mem_off", 32'({MEM_VALID, MEM_LOAD, MEM_ADDR_VALID}), 32'd0);
    check("tmo_ack_none", 32'(MEM_ACK_DATA_L1), 32'hF);
    MEM_READY = 1'b0;
    @(negedge CLK);
    check("tmo_err_pulse", 32'(ERR), 32'd0);

    // Asynchronous reset in the middle of a fill, then a clean fill.
    do_load(32'h0000_0A04, 32'h0000_0A00, 1'b0, 1'b0, 2);
    #1;
    RST_N = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(REQ_READY), 32'd1);
    check("mid_rst_fill", 32'({FILL_VALID, FILL_IDX}), 32'd0);
    check("mid_rst_fill_data", FILL_DATA, 32'd0);
    check("mid_rst_mem", 32'({MEM_VALID, MEM_LOAD, MEM_STORE, MEM_ADDR_VALID}), 32'd0);
    check("mid_rst_mem_addr", MEM_ADDR, 32'd0);
    check("mid_rst_ack", 32'(MEM_ACK_DATA_L1), 32'hF);
    MEM_READY = 1'b0;
    MEM_ACK_DATA_MEM = 4'hF;
    @(negedge CLK);
    RST_N = 1'b1;
    do_load(32'h0000_0BFC, 32'h0000_0BE0, 1'b0, 1'b0, -1);

    // REQ_VALID held while busy.
    txn_snap = txn_cnt;
    fill_snap = fill_cnt;
    do_load(32'h0000_3010, 32'h0000_3000, 1'b0, 1'b1, -1);
    repeat (2) @(negedge CLK);
    #1;
    check("busy_one_txn", 32'(txn_cnt - txn_snap), 32'd1);
    check("busy_fill_cnt", 32'(fill_cnt - fill_snap), 32'd8);
    check("busy_idle", 32'(REQ_READY), 32'd1);

    check("total_done", 32'(done_cnt), 32'd5);
    check("total_err", 32'(err_cnt), 32'd1);
    check("total_txn", 32'(txn_cnt), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_refill_controller.md
Name: l1_refill_controller

Overview:
- Sits between the L1 cache and main memory. Converts a single L1 miss into a main-memory line fill, or a single L1 write-through into a one-word memory store.
- Runs the memory request handshake: VALID/READY, then address ack, then per-word data-index ack.
- Delivers fill words to the L1 data array one word per beat with the word index.
- Owns the memory-side sequencing so the cache controller only issues one request and waits for DONE or ERR.

Parameters:
- WORDS_PER_LINE, 8, words per cache line; sets the fill length and the index width (3 bits).
- TIMEOUT_CYCLES, 256, cycles without handshake progress before the request is abandoned.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  asynchronous active-low reset.
- REQ_VALID  in  1  L1 request strobe.
- REQ_WRITE  in  1  1 = word store, 0 = line fill.
- REQ_ADDR  in  32  byte address.
- REQ_WDATA  in  32  store data.
- REQ_READY  out  1  controller idle and accepting a request.
- FILL_VALID  out  1  one-cycle strobe per fill word.
- FILL_IDX  out  3  index of the fill word within the line.
- FILL_DATA  out  32  fill word.
- FILL_LINE_ADDR  out  32  line base address (REQ_ADDR & ~32'h1F).
- DONE  out  1  one-cycle pulse when the request completes.
- ERR  out  1  one-cycle pulse when the request times out.
- MEM_VALID  out  1  memory transaction active.
- MEM_LOAD  out  1  transaction is a line load.
- MEM_STORE  out  1  transaction is a word store.
- MEM_READY  in  1  memory has accepted the transaction.
- MEM_ADDR  out  32  transaction address.
- MEM_ADDR_VALID  out  1  MEM_ADDR is valid (ACK_ADDR semantics).
- MEM_ADDR_TAKEN  in  1  memory has latched the address.
- MEM_RDATA  in  32  load data from memory.
- MEM_WDATA  out  32  store data to memory.
- MEM_ACK_DATA_MEM  in  4  index of the word memory is driving; 4'hF = none.
- MEM_ACK_DATA_L1  out  4  index of the last word the controller consumed; 4'hF = none.

Behaviour:
- Clocking: single clock CLK; RST_N is asynchronous and active-low. Asserting RST_N low at any time, including mid-transfer, forces state IDLE immediately.
- Reset values: REQ_READY=1; MEM_ACK_DATA_L1=4'hF; all other outputs 0. Latched address, data and counters are cleared.
- All outputs are registered.
- FSM states: IDLE, REQ, ADDR, LDATA, SDATA, FIN.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID, latch REQ_ADDR with bits [1:0] forced to 0, plus REQ_WDATA and REQ_WRITE. Go to REQ, with REQ_READY=0 from the next cycle.
- REQ:
  - MEM_VALID=1; MEM_LOAD=!write; MEM_STORE=write.
  - Go to ADDR when MEM_READY=1.
- ADDR:
  - MEM_ADDR_VALID=1; MEM_ADDR = line base for a load, word address for a store.
  - When MEM_ADDR_TAKEN=1: drop MEM_ADDR_VALID. A load goes to LDATA with expect=0; a store goes to SDATA.
- LDATA:
  - Act only when MEM_ACK_DATA_MEM == expect. Then capture MEM_RDATA, pulse FILL_VALID with FILL_IDX=expect, and set MEM_ACK_DATA_L1=expect.
  - expect==7: go to FIN. Otherwise increment expect.
  - Any other index, including a repeated one, is ignored and produces no FILL_VALID.
- SDATA:
  - MEM_WDATA = latched data; MEM_ACK_DATA_L1=4'h0.
  - Go to FIN when MEM_READY falls to 0.
- FIN:
  - Clear MEM_VALID, MEM_LOAD and MEM_STORE; set MEM_ACK_DATA_L1=4'hF; pulse DONE for one cycle.
  - Go to IDLE once MEM_READY=0.
- Timeout:
  - A progress counter resets on every state change and every accepted word.
  - Reaching TIMEOUT_CYCLES in any non-IDLE state pulses ERR, drives all MEM_* outputs to their reset values, and returns to IDLE. DONE is not pulsed.
- Ignored inputs: REQ_VALID while busy is ignored (no queueing). MEM_* inputs in IDLE are ignored.
- Best-case load latency is 12 cycles from request accept to DONE with a zero-wait memory: REQ 1, ADDR 1, 8 data beats, FIN 1, plus accept.

Decomposition:
- Shared package l1_mem_pkg:
  - state enum;
  - LINE_BYTES=32;
  - IDX_NONE=4'hF;
  - line_base() function.
- Sub-module mem_timeout_ctr: counter with clear, enable and an expired flag. Reused for the fill-side timeout.

Test Plan:
- Load, REQ_ADDR=32'h0000_0047 -> MEM_ADDR=32'h0000_0040; eight FILL_VALID pulses with FILL_IDX 0..7 carrying the memory words in order; DONE one cycle after idx 7; MEM_ACK_DATA_L1 ends at 4'hF.
- Store, REQ_ADDR=32'h0000_0106, REQ_WDATA=32'hDEAD_BEEF -> MEM_ADDR=32'h0000_0104; MEM_WDATA=32'hDEAD_BEEF with MEM_ACK_DATA_L1=0; DONE after MEM_READY drops; no FILL_VALID.
- Load where memory repeats index 3 and then presents 4 -> exactly one FILL_VALID for idx 3; fill completes normally.
- MEM_ADDR_TAKEN held 0 for 256 cycles -> ERR pulse, no DONE, REQ_READY=1 on the next cycle, MEM_VALID=0.
- RST_N low during LDATA after idx 2 -> all outputs return to reset values immediately; a subsequent load fills idx 0..7 cleanly.
- REQ_VALID re-asserted during a busy fill -> ignored; only one memory transaction is observed.
